// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared ALU control codes, FSM encoding and opcode helpers
// Contents: ALUCTL_* codes (shared with the decoder), state_t, opcode predicates.
package muldiv_pkg;

  localparam logic [4:0] ALUCTL_MULT  = 5'b00100;
  localparam logic [4:0] ALUCTL_MULTU = 5'b10101;
  localparam logic [4:0] ALUCTL_DIV   = 5'b00011;
  localparam logic [4:0] ALUCTL_DIVU  = 5'b10100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  function automatic logic is_muldiv(input logic [4:0] code);
    return (code == ALUCTL_MULT) || (code == ALUCTL_MULTU) ||
           (code == ALUCTL_DIV)  || (code == ALUCTL_DIVU);
  endfunction

  function automatic logic is_div_op(input logic [4:0] code);
    return (code == ALUCTL_DIV) || (code == ALUCTL_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [4:0] code);
    return (code == ALUCTL_MULT) || (code == ALUCTL_DIV);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// rtl/muldiv_if.sv - EX-stage multiply/divide handshake and HI/LO bundle
// Signals: start, aluctl, srca, srcb, hilo_rd, flush (pipeline -> unit);
//          busy, stall, done, hi, lo (unit -> pipeline).
// Modports: master = pipeline/hazard side, slave = muldiv_seq.
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [4:0]       aluctl;
  logic [WIDTH-1:0] srca;
  logic [WIDTH-1:0] srcb;
  logic             hilo_rd;
  logic             flush;
  logic             busy;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, aluctl, srca, srcb, hilo_rd, flush,
    input  busy, stall, done, hi, lo
  );

  modport slave (
    input  start, aluctl, srca, srcb, hilo_rd, flush,
    output busy, stall, done, hi, lo
  );
endinterface

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one radix-2 iteration: multiply add-shift or restoring divide step
// Ports: is_div selects divide; acc = upper accumulator / partial remainder;
//        mq = multiplier+product low / dividend+quotient; opb = multiplicand / divisor;
//        acc_n, mq_n = register values after this iteration.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] mq,
  input  logic [WIDTH-1:0] opb,
  output logic [WIDTH-1:0] acc_n,
  output logic [WIDTH-1:0] mq_n
);
  logic [WIDTH:0] sum;
  logic [WIDTH:0] mul_hi;
  logic [WIDTH:0] shl;
  logic           ge;

  always_comb begin
    sum    = {1'b0, acc} + {1'b0, opb};
    mul_hi = mq[0] ? sum : {1'b0, acc};
    // The partial remainder needs one extra bit after the shift before the compare.
    shl    = {acc, mq[WIDTH-1]};
    ge     = (shl >= {1'b0, opb});
    if (is_div) begin
      // When ge holds the true difference is below 2**WIDTH, so truncation is exact.
      acc_n = ge ? (shl[WIDTH-1:0] - opb) : shl[WIDTH-1:0];
      mq_n  = {mq[WIDTH-2:0], ge};
    end else begin
      acc_n = mul_hi[WIDTH:1];
      mq_n  = {mul_hi[0], mq[WIDTH-1:1]};
    end
  end
endmodule

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - iterative mult/multu/div/divu sequencer with HI/LO and hazard stall
// Ports: clk, rst_n (async active-low); bus (muldiv_if.slave): start/aluctl/srca/srcb
//        launch an op, hilo_rd marks an mfhi/mflo, flush aborts; busy/stall/done/hi/lo out.
// Option: define MULDIV_EARLY_OUT_EN to finish a multiply as soon as the remaining
//         multiplier bits are zero.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic       clk,
  input logic       rst_n,
  muldiv_if.slave   bus
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   acc, mq, opb, hi, lo;
  logic               is_div, neg_lo, neg_hi, div0, done;
  logic [WIDTH-1:0]   step_acc, step_mq, nxt_acc, nxt_mq;
  logic [WIDTH-1:0]   mag_a, mag_b, res_hi, res_lo;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic               accept, early, go_fix, sgn, sa, sb, op_div;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div (is_div),
    .acc    (acc),
    .mq     (mq),
    .opb    (opb),
    .acc_n  (step_acc),
    .mq_n   (step_mq)
  );

  assign accept = bus.start && is_muldiv(bus.aluctl) && !bus.flush;
  assign op_div = is_div_op(bus.aluctl);
  assign sgn    = is_signed_op(bus.aluctl);
  assign sa     = sgn & bus.srca[WIDTH-1];
  assign sb     = sgn & bus.srcb[WIDTH-1];
  assign mag_a  = sa ? -bus.srca : bus.srca;
  assign mag_b  = sb ? -bus.srcb : bus.srcb;

`ifdef MULDIV_EARLY_OUT_EN
  logic [CNT_W-1:0]   cnt_nx, rem_cnt;
  logic [WIDTH-1:0]   upper_mask;
  logic [2*WIDTH-1:0] bulk;
  // mq[WIDTH-1-cnt:1] are the multiplier bits not yet consumed after this step.
  assign cnt_nx     = cnt + CNT_W'(1);
  assign upper_mask = {WIDTH{1'b1}} >> cnt_nx;
  assign early      = !is_div && (((mq >> 1) & upper_mask) == '0);
  assign rem_cnt    = LAST - cnt;
  // With no more adds, the remaining iterations reduce to a plain right shift.
  assign bulk       = {step_acc, step_mq} >> rem_cnt;
  assign nxt_acc    = early ? bulk[2*WIDTH-1:WIDTH] : step_acc;
  assign nxt_mq     = early ? bulk[WIDTH-1:0] : step_mq;
`else
  assign early      = 1'b0;
  assign nxt_acc    = step_acc;
  assign nxt_mq     = step_mq;
`endif

  assign go_fix = (cnt == LAST) || early;

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = CALC;
      CALC:    if (bus.flush) state_n = IDLE;
               else if (go_fix) state_n = FIX;
      FIX:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Sign fixup; a zero divisor forces an all-ones quotient while the remainder,
  // being the dividend magnitude re-signed, already equals the raw dividend.
  always_comb begin
    prod     = {acc, mq};
    prod_fix = neg_lo ? -prod : prod;
    if (is_div) begin
      res_hi = neg_hi ? -acc : acc;
      res_lo = div0 ? {WIDTH{1'b1}} : (neg_lo ? -mq : mq);
    end else begin
      res_hi = prod_fix[2*WIDTH-1:WIDTH];
      res_lo = prod_fix[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      acc    <= '0;
      mq     <= '0;
      opb    <= '0;
      is_div <= 1'b0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      div0   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          cnt    <= '0;
          acc    <= '0;
          mq     <= op_div ? mag_a : mag_b;
          opb    <= op_div ? mag_b : mag_a;
          is_div <= op_div;
          neg_lo <= sa ^ sb;
          neg_hi <= sa;
          div0   <= op_div && (bus.srcb == '0);
        end
        CALC: begin
          cnt <= cnt + CNT_W'(1);
          acc <= nxt_acc;
          mq  <= nxt_mq;
        end
        FIX: if (!bus.flush) begin
          hi   <= res_hi;
          lo   <= res_lo;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy  = (state != IDLE);
  assign bus.stall = bus.busy & (bus.start | bus.hilo_rd);
  assign bus.done  = done;
  assign bus.hi    = hi;
  assign bus.lo    = lo;
endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - self-checking bench for muldiv_seq (vector table, scoreboard, corner sequences)
module tb_muldiv_seq;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  muldiv_if #(.WIDTH(32)) bus ();

  muldiv_seq #(.WIDTH(32), .CNT_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  code;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;

  int   total = 0;
  int   passed = 0;
  exp_t exp_q[$];
  vec_t vt[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
  endtask

  function automatic int exp_lat(input logic [4:0] code, input logic [31:0] b);
    int          lat;
    logic [31:0] m;
    lat = 33;
    m   = b;
`ifdef MULDIV_EARLY_OUT_EN
    if (!is_div_op(code)) begin
      if (code == ALUCTL_MULT && b[31]) m = -b;
      lat = 2;
      for (int i = 0; i < 32; i++) if (m[i]) lat = 2 + i;
    end
`endif
    return lat;
  endfunction

  function automatic vec_t model(input logic [4:0] code, input logic [31:0] a, input logic [31:0] b);
    vec_t               v;
    logic [63:0]        p;
    logic signed [63:0] x, y;
    logic signed [31:0] sa, sb;
    v.code = code; v.a = a; v.b = b;
    sa = $signed(a); sb = $signed(b);
    case (code)
      ALUCTL_MULTU: begin p = {32'h0, a} * {32'h0, b}; v.hi = p[63:32]; v.lo = p[31:0]; end
      ALUCTL_MULT: begin
        x = $signed({{32{a[31]}}, a}); y = $signed({{32{b[31]}}, b});
        p = x * y; v.hi = p[63:32]; v.lo = p[31:0];
      end
      ALUCTL_DIVU: begin v.lo = a / b; v.hi = a % b; end
      default: begin v.lo = sa / sb; v.hi = sa % sb; end
    endcase
    return v;
  endfunction

  // Called at a falling edge; returns just after the accepting rising edge (E0).
  task automatic drive_op(input logic [4:0] code, input logic [31:0] a, input logic [31:0] b);
    bus.aluctl = code; bus.srca = a; bus.srcb = b; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  // Counts rising edges until done is seen at a falling edge; bounded.
  task automatic wait_done(output int lat, output bit ok);
    lat = 0; ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (bus.done === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic score(input string tag, input int lat, input bit ok);
    exp_t e;
    check($sformatf("%s_done", tag), ok, 1);
    check($sformatf("%s_sb_nonempty", tag), exp_q.size() > 0, 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check($sformatf("%s_hi", tag), bus.hi, e.hi);
      check($sformatf("%s_lo", tag), bus.lo, e.lo);
      check($sformatf("%s_lat", tag), lat, e.lat);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    exp_t e;
    int   lat;
    bit   ok;
    e.hi = v.hi; e.lo = v.lo; e.lat = exp_lat(v.code, v.b);
    drive_op(v.code, v.a, v.b);
    exp_q.push_back(e);
    wait_done(lat, ok);
    score(tag, lat, ok);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int    lat, nd;
    bit    ok;
    exp_t  e;
    vec_t  v;
    logic [4:0] codes[4];

    bus.start = 0; bus.aluctl = '0; bus.srca = '0; bus.srcb = '0;
    bus.hilo_rd = 0; bus.flush = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_stall", bus.stall, 0);
    check("rst_hi", bus.hi, 0);
    check("rst_lo", bus.lo, 0);
    rst_n = 1'b1;
    @(negedge clk);

    vt.push_back('{ALUCTL_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001});
    vt.push_back('{ALUCTL_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB});
    vt.push_back('{ALUCTL_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD});
    vt.push_back('{ALUCTL_DIVU,  32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF});
    vt.push_back('{ALUCTL_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000});
    vt.push_back('{ALUCTL_MULT,  32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001});
    vt.push_back('{ALUCTL_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000});
    vt.push_back('{ALUCTL_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF});
    vt.push_back('{ALUCTL_DIV,   32'h00000064, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFF2});
    vt.push_back('{ALUCTL_DIV,   32'hFFFFFF9C, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFF2});
    vt.push_back('{ALUCTL_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF});
    vt.push_back('{ALUCTL_MULT,  32'h12345678, 32'h00000000, 32'h00000000, 32'h00000000});
    vt.push_back('{ALUCTL_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000});
    vt.push_back('{ALUCTL_MULTU, 32'h00000003, 32'h00000005, 32'h00000000, 32'h0000000F});

    codes[0] = ALUCTL_MULTU; codes[1] = ALUCTL_MULT; codes[2] = ALUCTL_DIVU; codes[3] = ALUCTL_DIV;
    for (int i = 0; i < 8; i++) begin
      logic [31:0] a, b;
      a = $urandom; b = $urandom;
      if (is_div_op(codes[i % 4]) && b == 0) b = 32'd1;
      if (codes[i % 4] == ALUCTL_DIV && a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd3;
      vt.push_back(model(codes[i % 4], a, b));
    end

    for (int i = 0; i < vt.size(); i++) run_vec(vt[i], $sformatf("vec%0d", i));

    // Busy unit: new start and mfhi/mflo must stall, and the running op must not restart.
    drive_op(ALUCTL_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    e.hi = 32'hFFFFFFFE; e.lo = 32'h00000001; e.lat = 22;
    exp_q.push_back(e);
    repeat (9) @(posedge clk);
    @(negedge clk);
    bus.start = 1; bus.aluctl = ALUCTL_DIVU; bus.srca = 32'd5; bus.srcb = 32'd1; bus.hilo_rd = 1;
    #1 check("stall_start_hilo", bus.stall, 1);
    @(posedge clk);
    #1 bus.start = 0; bus.hilo_rd = 0;
    @(negedge clk);
    bus.hilo_rd = 1;
    #1 check("stall_hilo", bus.stall, 1);
    check("stall_busy", bus.busy, 1);
    @(posedge clk);
    #1 bus.hilo_rd = 0;
    wait_done(lat, ok);
    score("stall_op", lat, ok);
    // Back-to-back: start presented in the done cycle is accepted immediately.
    bus.aluctl = ALUCTL_MULTU; bus.srca = 32'd6; bus.srcb = 32'd7; bus.start = 1;
    #1 check("b2b_stall", bus.stall, 0);
    check("b2b_idle", bus.busy, 0);
    e.hi = 0; e.lo = 32'd42; e.lat = exp_lat(ALUCTL_MULTU, 32'd7);
    exp_q.push_back(e);
    @(posedge clk);
    #1 bus.start = 0;
    @(negedge clk);
    check("b2b_busy", bus.busy, 1);
    check("done_pulse", bus.done, 0);
    lat = 0; ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      lat++;
      if (bus.done === 1'b1) begin ok = 1; break; end
      @(posedge clk);
    end
    score("b2b_op", lat, ok);

    // Establish known HI/LO, then flush a divu in CALC.
    v = '{ALUCTL_MULTU, 32'h22222222, 32'h80000001, 32'h11111111, 32'h22222222};
    run_vec(v, "preload");
    drive_op(ALUCTL_DIVU, 32'h12345678, 32'd3);
    repeat (20) @(posedge clk);
    @(negedge clk);
    bus.flush = 1;
    @(posedge clk);
    #1 bus.flush = 0;
    @(negedge clk);
    check("flush_busy", bus.busy, 0);
    check("flush_hi", bus.hi, 32'h11111111);
    check("flush_lo", bus.lo, 32'h22222222);
    nd = 0;
    repeat (40) begin @(negedge clk); if (bus.done) nd++; end
    check("flush_no_done", nd, 0);

    // Flush in the FIX cycle wins over the HI/LO write.
    drive_op(ALUCTL_DIVU, 32'd100, 32'd7);
    repeat (32) @(posedge clk);
    @(negedge clk);
    check("fix_busy", bus.busy, 1);
    bus.flush = 1;
    @(posedge clk);
    #1 bus.flush = 0;
    @(negedge clk);
    check("fixflush_busy", bus.busy, 0);
    check("fixflush_done", bus.done, 0);
    check("fixflush_hi", bus.hi, 32'h11111111);
    check("fixflush_lo", bus.lo, 32'h22222222);

    // Start ignored for a non-muldiv code and when flush accompanies it.
    bus.aluctl = 5'b00010; bus.start = 1;
    @(posedge clk);
    #1 bus.start = 0;
    @(negedge clk);
    check("bad_code_busy", bus.busy, 0);
    bus.aluctl = ALUCTL_MULTU; bus.start = 1; bus.flush = 1;
    @(posedge clk);
    #1 bus.start = 0; bus.flush = 0;
    @(negedge clk);
    check("flush_start_busy", bus.busy, 0);

    // Asynchronous reset mid-multiply.
    drive_op(ALUCTL_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (15) @(posedge clk);
    #2 rst_n = 0;
    #1;
    check("arst_busy", bus.busy, 0);
    check("arst_done", bus.done, 0);
    check("arst_hi", bus.hi, 0);
    check("arst_lo", bus.lo, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    v = '{ALUCTL_MULTU, 32'd3, 32'd5, 32'd0, 32'd15};
    run_vec(v, "post_rst");
    check("sb_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
